// File: rtl/inert_pkg.sv
// Shared types and command constants for the inertial sensor sequencer.
// Read commands are the register address with the read bit set, in the high byte.
package inert_pkg;

    typedef enum logic [2:0] {
        ST_RST_WAIT = 3'd0,
        ST_CFG_SEND = 3'd1,
        ST_CFG_WAIT = 3'd2,
        ST_WAIT_INT = 3'd3,
        ST_RD_SEND  = 3'd4,
        ST_RD_WAIT  = 3'd5
    } state_e;

    localparam logic [15:0] CFG_INT_EN = 16'h0D02;
    localparam logic [15:0] CFG_ACCEL  = 16'h1053;
    localparam logic [15:0] CFG_GYRO   = 16'h1150;
    localparam logic [15:0] CFG_ROUND  = 16'h1460;

    localparam logic [7:0] RD_BIT      = 8'h80;
    localparam logic [7:0] ADDR_PTCH_L = 8'h24;
    localparam logic [7:0] ADDR_PTCH_H = 8'h25;
    localparam logic [7:0] ADDR_AZ_L   = 8'h2C;
    localparam logic [7:0] ADDR_AZ_H   = 8'h2D;

    function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
        logic [15:0] c;
        case (idx)
            2'd0:    c = CFG_INT_EN;
            2'd1:    c = CFG_ACCEL;
            2'd2:    c = CFG_GYRO;
            default: c = CFG_ROUND;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] rd_cmd(input logic [1:0] idx);
        logic [7:0] a;
        case (idx)
            2'd0:    a = ADDR_PTCH_L;
            2'd1:    a = ADDR_PTCH_H;
            2'd2:    a = ADDR_AZ_L;
            default: a = ADDR_AZ_H;
        endcase
        return {RD_BIT | a, 8'h00};
    endfunction

endpackage

// File: rtl/inert_seq_sync2.sv
// Two-flop synchronizer for the asynchronous sensor data-ready line.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/inert_seq.sv
// Inertial sensor sequencer: power-up wait, config writes, then a four-byte
// read burst per data-ready interrupt, presenting pitch rate and Z accel.
//
// state       | meaning
// ------------+------------------------------------------------
// RST_WAIT    | power-up wait, timer counting to all-ones
// CFG_SEND    | wrt pulse with config command for idx
// CFG_WAIT    | waiting for done of a config write
// WAIT_INT    | idle, waiting for synchronized data-ready
// RD_SEND     | wrt pulse with read command for idx
// RD_WAIT     | waiting for done of a read, capture byte
module inert_seq
    import inert_pkg::*;
#(
    parameter int TMR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        cmd_q, cmd_d;
    logic [15:0]        ptch_q, ptch_d;
    logic [15:0]        az_q, az_d;
    logic [7:0]         lo_q, lo_d;
    logic               vld_q, vld_d;
    logic               int_ff2;
    logic               unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (INT),
        .q_o   (int_ff2)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        ptch_d  = ptch_q;
        az_d    = az_q;
        lo_d    = lo_q;
        vld_d   = 1'b0;
        case (state_q)
            ST_RST_WAIT: begin
                tmr_d = tmr_q + TMR_ONE;
                if (&tmr_q) begin
                    idx_d   = 2'd0;
                    cmd_d   = cfg_cmd(2'd0);
                    state_d = ST_CFG_SEND;
                end
            end
            ST_CFG_SEND: state_d = ST_CFG_WAIT;
            ST_CFG_WAIT: begin
                if (done) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_WAIT_INT;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        cmd_d   = cfg_cmd(idx_q + 2'd1);
                        state_d = ST_CFG_SEND;
                    end
                end
            end
            ST_WAIT_INT: begin
                if (int_ff2) begin
                    idx_d   = 2'd0;
                    cmd_d   = rd_cmd(2'd0);
                    state_d = ST_RD_SEND;
                end
            end
            ST_RD_SEND: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (done) begin
                    // low bytes are staged so each 16-bit output changes only once
                    case (idx_q)
                        2'd0: lo_d   = rd_data[7:0];
                        2'd1: ptch_d = {rd_data[7:0], lo_q};
                        2'd2: lo_d   = rd_data[7:0];
                        2'd3: begin
                            az_d  = {rd_data[7:0], lo_q};
                            vld_d = 1'b1;
                        end
                    endcase
                    if (idx_q == 2'd3) begin
                        state_d = ST_WAIT_INT;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        cmd_d   = rd_cmd(idx_q + 2'd1);
                        state_d = ST_RD_SEND;
                    end
                end
            end
            default: state_d = ST_RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST_WAIT;
            tmr_q   <= '0;
            idx_q   <= 2'd0;
            cmd_q   <= 16'h0000;
            ptch_q  <= 16'h0000;
            az_q    <= 16'h0000;
            lo_q    <= 8'h00;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            ptch_q  <= ptch_d;
            az_q    <= az_d;
            lo_q    <= lo_d;
            vld_q   <= vld_d;
        end
    end

    assign wrt     = (state_q == ST_CFG_SEND) || (state_q == ST_RD_SEND);
    assign cmd     = cmd_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;
    assign vld     = vld_q;

endmodule

// File: tb/tb_inert_seq.sv
// Scoreboard bench for inert_seq with a delayed-done SPI model.
module tb_inert_seq;

    localparam int DONE_LAT = 20;
    localparam logic [15:0] CFG_CMDS [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    localparam logic [15:0] RD_CMDS  [4] = '{16'hA400, 16'hA500, 16'hAC00, 16'hAD00};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        mdl_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [15:0] mdl_rd = 16'h0000;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt, vld;
    logic [15:0] cmd, ptch_rt, AZ;

    assign done    = mdl_done | spur_done;
    assign rd_data = mdl_rd;

    inert_seq #(.TMR_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    logic [15:0] exp_cmd_q [$];
    logic [31:0] exp_smp_q [$];
    logic [31:0] resp_q [$];

    int cyc = 0;
    int wrt_cnt = 0;
    int vld_cnt = 0;
    int done_cnt = 0;
    int int_cyc = 0;
    int ad_done_cyc = 0;
    int last_vld_cyc = 0;
    bit first_pend = 0;
    bit lat_pend = 0;
    bit b2b_arm = 0;
    bit b2b_pend = 0;
    bit pend = 0;
    int pend_cnt = 0;
    logic [15:0] pend_cmd = 16'h0000;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [15:0] resp(input logic [15:0] c);
        logic [31:0] s;
        logic [15:0] r;
        s = (resp_q.size() > 0) ? resp_q[0] : 32'hEEEE_EEEE;
        case (c)
            16'hA400: r = {8'hE5, s[23:16]};
            16'hA500: r = {8'hE5, s[31:24]};
            16'hAC00: r = {8'hE5, s[7:0]};
            16'hAD00: r = {8'hE5, s[15:8]};
            default:  r = 16'hE500;
        endcase
        return r;
    endfunction

    // SPI monarch model: done one cycle, DONE_LAT cycles after each wrt
    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mdl_done = 1'b1;
                    mdl_rd   = resp(pend_cmd);
                    done_cnt++;
                    pend = 0;
                    if (pend_cmd == 16'hAD00) begin
                        ad_done_cyc = cyc;
                        if (resp_q.size() > 0) void'(resp_q.pop_front());
                    end
                end
            end
            if (wrt) begin
                check("wrt_while_busy", {31'd0, pend}, 32'd0);
                pend     = 1;
                pend_cnt = DONE_LAT;
                pend_cmd = cmd;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (wrt) begin
                wrt_cnt++;
                if (first_pend) begin
                    check("first_wrt_cycle", cyc, 16);
                    first_pend = 0;
                end
                if (lat_pend) begin
                    check("int_to_wrt", cyc - int_cyc, 3);
                    lat_pend = 0;
                end
                if (b2b_pend) begin
                    check("b2b_gap", cyc - last_vld_cyc, 1);
                    b2b_pend = 0;
                end
                check("wrt_expected", {31'd0, exp_cmd_q.size() > 0}, 32'd1);
                if (exp_cmd_q.size() > 0) check("cmd", {16'd0, cmd}, {16'd0, exp_cmd_q.pop_front()});
            end
            if (vld) begin
                logic [31:0] s;
                vld_cnt++;
                last_vld_cyc = cyc;
                if (b2b_arm) b2b_pend = 1;
                check("vld_after_ad_done", cyc - ad_done_cyc, 1);
                check("vld_expected", {31'd0, exp_smp_q.size() > 0}, 32'd1);
                if (exp_smp_q.size() > 0) begin
                    s = exp_smp_q.pop_front();
                    check("ptch_rt", {16'd0, ptch_rt}, {16'd0, s[31:16]});
                    check("AZ", {16'd0, AZ}, {16'd0, s[15:0]});
                end
            end
        end
    end

    task automatic push_cfg();
        for (int i = 0; i < 4; i++) exp_cmd_q.push_back(CFG_CMDS[i]);
    endtask

    task automatic push_burst(input logic [15:0] pr, input logic [15:0] az);
        exp_smp_q.push_back({pr, az});
        resp_q.push_back({pr, az});
        for (int i = 0; i < 4; i++) exp_cmd_q.push_back(RD_CMDS[i]);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        check("done_count", done_cnt, target);
    endtask

    task automatic wait_vld(input int target, input int budget);
        for (int i = 0; i < budget && vld_cnt < target; i++) @(negedge clk);
        check("vld_count", vld_cnt, target);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wrt"}, {31'd0, wrt}, 32'd0);
        check({tag, "_cmd"}, {16'd0, cmd}, 32'd0);
        check({tag, "_ptch"}, {16'd0, ptch_rt}, 32'd0);
        check({tag, "_az"}, {16'd0, AZ}, 32'd0);
        check({tag, "_vld"}, {31'd0, vld}, 32'd0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        #1 check_zero("reset");

        push_cfg();
        first_pend = 1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(4, 400);
        repeat (5) @(negedge clk);

        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (10) @(negedge clk);
        check("spur_wait_int_wrt", wrt_cnt, 4);
        check("spur_wait_int_ptch", {16'd0, ptch_rt}, 32'd0);
        check("spur_wait_int_az", {16'd0, AZ}, 32'd0);

        // single burst, with a stray done landing in RD_SEND
        push_burst(16'h1234, 16'hABCD);
        lat_pend = 1;
        int_cyc = cyc;
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        @(negedge clk);
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        wait_vld(1, 300);
        @(negedge clk);
        check("burst1_ptch", {16'd0, ptch_rt}, 32'h1234);
        check("burst1_az", {16'd0, AZ}, 32'hABCD);
        check("burst1_vld_low", {31'd0, vld}, 32'd0);

        // one-cycle INT glitch while reading
        push_burst(16'h5678, 16'h9ABC);
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        repeat (30) @(negedge clk);
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        wait_vld(2, 300);
        repeat (150) @(negedge clk);
        check("glitch_single_vld", vld_cnt, 2);

        // INT held high: back-to-back bursts
        push_burst(16'h0F1E, 16'h2D3C);
        push_burst(16'h4B5A, 16'h6978);
        push_burst(16'h8796, 16'hA5B4);
        b2b_arm = 1;
        INT = 1'b1;
        wait_vld(4, 600);
        INT = 1'b0;
        b2b_arm = 0;
        wait_vld(5, 300);
        repeat (150) @(negedge clk);
        check("held_vld_total", vld_cnt, 5);

        // reset during the AZ low-byte read
        push_burst(16'hDEAD, 16'hBEEF);
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        for (int i = 0; i < 200 && !(pend && pend_cmd == 16'hAC00); i++) @(negedge clk);
        check("reach_az_lo", {16'd0, pend_cmd}, 32'h0000AC00);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero("midreset");
        exp_cmd_q.delete();
        exp_smp_q.delete();
        resp_q.delete();
        repeat (3) @(negedge clk);
        check("midreset_no_vld", vld_cnt, 5);
        push_cfg();
        first_pend = 1;
        base = done_cnt;
        rst_n = 1'b1;
        wait_done(base + 4, 400);
        repeat (5) @(negedge clk);
        push_burst(16'h0102, 16'h0304);
        INT = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        wait_vld(6, 300);
        repeat (20) @(negedge clk);

        check("cmd_q_drained", exp_cmd_q.size(), 0);
        check("smp_q_drained", exp_smp_q.size(), 0);
        check("final_ptch", {16'd0, ptch_rt}, 32'h0102);
        check("final_az", {16'd0, AZ}, 32'h0304);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/inert_seq.md
# inert_seq

Sequencer for the inertial sensor that feeds the pitch integrator. After reset it waits for the sensor to power up, then writes the configuration registers. It then services each data-ready interrupt by reading pitch-rate and Z-acceleration bytes over the SPI monarch's transaction port. Each time a sample is complete it presents 16-bit `ptch_rt` and `AZ` with a one-cycle `vld` strobe for the integrator.

## Interface
- `TMR_W`, default 16: power-up wait counter width. The wait lasts 2^TMR_W cycles; benches use 4.
- `clk` input, 1 bit: system clock; all state is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `INT` input, 1 bit: sensor data-ready, asynchronous to `clk`, active-high level.
- `done` input, 1 bit: SPI monarch one-cycle pulse; the transaction is complete and `rd_data` is valid.
- `rd_data` input, 16 bits: SPI read-back; only `[7:0]` is used.
- `wrt` output, 1 bit: one-cycle pulse that launches an SPI transaction.
- `cmd` output, 16 bits: SPI command word, stable from `wrt` through `done`.
- `ptch_rt` output, 16 bits: pitch rate, `{high byte, low byte}`.
- `AZ` output, 16 bits: Z acceleration, `{high byte, low byte}`.
- `vld` output, 1 bit: one-cycle pulse; `ptch_rt` and `AZ` hold a complete new sample.

## Operation
- `INT` passes through a 2-flop synchronizer; only the synchronized value `INT_ff2` is used.
- Configuration writes, in order:
  - idx0: 0x0D02, interrupt enable.
  - idx1: 0x1053, accel config.
  - idx2: 0x1150, gyro config.
  - idx3: 0x1460, rounding.
- Data reads, in order (`cmd` = `{8'hXX, 8'h00}`):
  - idx0: 0xA4, pitch low.
  - idx1: 0xA5, pitch high.
  - idx2: 0xAC, AZ low.
  - idx3: 0xAD, AZ high.
- FSM states and transitions:
  - RST_WAIT: timer counts up each cycle. On all-ones go to CFG_SEND and clear idx.
  - CFG_SEND: pulse `wrt` with the config command for idx, then go to CFG_WAIT.
  - CFG_WAIT: on `done`, if idx==3 go to WAIT_INT, else idx++ and go to CFG_SEND.
  - WAIT_INT: when `INT_ff2`==1, clear idx and go to RD_SEND.
  - RD_SEND: pulse `wrt` with the read command for idx, then go to RD_WAIT.
  - RD_WAIT: on `done`, capture the byte and act on idx:
    - idx0: `ptch_rt` staging low byte.
    - idx1: write `ptch_rt` = `{rd_data[7:0], staged low}`.
    - idx2: `AZ` staging low byte.
    - idx3: write `AZ` = `{rd_data[7:0], staged low}`, set `vld` on the next edge, go to WAIT_INT.
    - idx<3: idx++ and go to RD_SEND.
- `INT` is level-sensitive. If `INT_ff2` is still high on return to WAIT_INT, a new read burst starts immediately.
- `done` arriving outside a WAIT state is ignored; `wrt` is never reissued before `done`.
- Arithmetic is unsigned. The timer saturates in effect because it is not used after RST_WAIT. idx is 2 bits and never wraps past 3 within a burst.

## Timing
- Reset values: `wrt`=0, `cmd`=0, `ptch_rt`=0, `AZ`=0, `vld`=0, state=RST_WAIT, timer=0, idx=0, synchronizer flops=0.
- Reset asserted mid-transaction, any state: everything returns to reset values asynchronously. The SPI monarch is reset by the same `rst_n`.
- First `wrt` fires on cycle 2^TMR_W after reset release, ±1.
- `wrt` comes from a registered state output, high for exactly one cycle; `cmd` is valid in the same cycle.
- Next `wrt` is no earlier than 1 cycle after `done` (a send state intervenes).
- `INT` rising to RD_SEND `wrt`: 3 cycles (2 sync + 1 state).
- `vld` is high the cycle after the idx3 read `done`, for 1 cycle.
- `AZ` updates on that same edge; `ptch_rt` updated earlier and does not change again in the burst.

## Structure
- Shared package `inert_pkg`:
  - state enum;
  - the four CFG command constants;
  - the four read address constants;
  - `RD_BIT` = 0x80 mask.
- Natural sub-module `sync2`: 2-flop synchronizer with async active-low reset to 0.
- The SPI monarch is a sibling instance in the parent, not inside this block.

## Test plan
- Reset release with TMR_W=4 and a `done` model answering 20 cycles after `wrt` → first `wrt` at cycle 16, then `cmd` 0x0D02, 0x1053, 0x1150, 0x1460 in order, each `wrt` after the prior `done`.
- `INT` pulse high, model returns 0x34, 0x12, 0xCD, 0xAB → read `cmd`s 0xA400, 0xA500, 0xAC00, 0xAD00; `ptch_rt`=0x1234; `AZ`=0xABCD with a single-cycle `vld` the cycle after the 4th `done`.
- `INT` held high continuously → back-to-back bursts, one `vld` per burst, no `wrt` overlap with an outstanding transaction.
- Spurious `done` in WAIT_INT or RD_SEND → no state change, no output change.
- `rst_n` dropped during RD_WAIT idx2 → all outputs 0 immediately, no `vld`; after release the power-up wait and full config sequence repeat.
- `INT` toggling 1 cycle only while the FSM is in RD_WAIT → ignored; the burst completes normally with exactly one `vld`.
